// File: rtl/rounding_sched_if.sv
// Handshake bundle for rounding_sched: per-channel sample inputs with ready,
// plus the single tagged output stream with downstream ready.
interface rounding_sched_if #(
  parameter int pN_CH   = 4,
  parameter int pIDAT_W = 24,
  parameter int pODAT_W = 8
);
  localparam int CH_W = $clog2(pN_CH);

  logic [pN_CH-1:0]          ival;
  logic [pN_CH*pIDAT_W-1:0]  idat;
  logic [pN_CH-1:0]          ordy;
  logic                      oval;
  logic [CH_W-1:0]           ochan;
  logic signed [pODAT_W-1:0] odat;
  logic                      iordy;

  modport master (output ival, idat, iordy, input ordy, oval, ochan, odat);
  modport slave  (input ival, idat, iordy, output ordy, oval, ochan, odat);
endinterface

// File: rtl/rounding_sched.sv
// Round-robin scheduler sharing one round-half-up/saturate stage between pN_CH
// requesters. Optional per-channel clip counters under ROUNDING_SCHED_STAT_EN.
module rounding_sched #(
  parameter int pN_CH       = 4,
  parameter int pIDAT_W     = 24,
  parameter int pODAT_W     = 8,
  parameter int pDIV        = 16,
  parameter int pFULL_SCALE = 0
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  rounding_sched_if.slave      bus
`ifdef ROUNDING_SCHED_STAT_EN
  ,
  input  logic                 iclr_stat,
  output logic [pN_CH*16-1:0]  osat_cnt
`endif
);

  localparam int CH_W    = $clog2(pN_CH);
  localparam int SUM_W   = pIDAT_W + 1;
  localparam int HALF_SH = (pDIV > 0) ? pDIV - 1 : 0;
  localparam logic signed [SUM_W-1:0] HALF = (pDIV > 0) ? (SUM_W'(1) << HALF_SH) : '0;
  localparam longint MAXL = (longint'(1) << (pODAT_W - 1)) - 1;
  localparam longint MINL = (pFULL_SCALE != 0) ? -MAXL - 1 : -MAXL;
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(MAXL);
  localparam logic signed [SUM_W-1:0] MINV = SUM_W'(MINL);
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(pN_CH);

  function automatic logic signed [SUM_W-1:0] rnd_shift(input logic signed [pIDAT_W-1:0] x);
    logic signed [SUM_W-1:0] sum;
    sum = {x[pIDAT_W-1], x} + HALF;
    return sum >>> pDIV;
  endfunction

  function automatic logic sat_clip(input logic signed [SUM_W-1:0] q);
    return (q > MAXV) || (q < MINV);
  endfunction

  function automatic logic signed [pODAT_W-1:0] sat_val(input logic signed [SUM_W-1:0] q);
    if (q > MAXV)      return MAXV[pODAT_W-1:0];
    else if (q < MINV) return MINV[pODAT_W-1:0];
    else               return q[pODAT_W-1:0];
  endfunction

  logic [pN_CH-1:0]          full_p0;
  logic signed [pIDAT_W-1:0] hold_p0 [pN_CH];
  logic [CH_W-1:0]           rr_p0;
  logic                      vld_p1;
  logic [CH_W-1:0]           ochan_p1;
  logic signed [pODAT_W-1:0] odat_p1;

  logic                      adv;
  logic                      win_vld;
  logic [CH_W-1:0]           win_idx;
  logic [CH_W:0]             cand;
  logic [CH_W:0]             rr_nxt;
  logic signed [SUM_W-1:0]   q_win;

  assign adv       = iclkena & (~vld_p1 | bus.iordy);
  assign bus.ordy  = ~full_p0;
  assign bus.oval  = vld_p1;
  assign bus.ochan = ochan_p1;
  assign bus.odat  = odat_p1;

  // Descending scan so the channel closest to the pointer is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = pN_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_p0} + (CH_W + 1)'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (full_p0[cand[CH_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    rr_nxt = {1'b0, win_idx} + (CH_W + 1)'(1);
    if (rr_nxt >= NCH) rr_nxt = '0;
  end

  assign q_win = rnd_shift(hold_p0[win_idx]);

  // Stage p0: per-channel holding registers and grant pointer
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      full_p0 <= '0;
      rr_p0   <= '0;
    end else if (iclkena) begin
      for (int i = 0; i < pN_CH; i++)
        if (bus.ival[i] && !full_p0[i]) full_p0[i] <= 1'b1;
      if (adv && win_vld) begin
        full_p0[win_idx] <= 1'b0;
        rr_p0            <= rr_nxt[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (iclkena)
      for (int i = 0; i < pN_CH; i++)
        if (bus.ival[i] && !full_p0[i]) hold_p0[i] <= bus.idat[i*pIDAT_W +: pIDAT_W];
  end

  // Stage p1: rounded/saturated output register, held while downstream stalls
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      vld_p1   <= 1'b0;
      ochan_p1 <= '0;
      odat_p1  <= '0;
    end else if (adv) begin
      vld_p1 <= win_vld;
      if (win_vld) begin
        ochan_p1 <= win_idx;
        odat_p1  <= sat_val(q_win);
      end
    end
  end

`ifdef ROUNDING_SCHED_STAT_EN
  logic [15:0] sat_cnt [pN_CH];

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < pN_CH; i++) sat_cnt[i] <= '0;
    end else if (iclkena) begin
      if (iclr_stat) begin
        for (int i = 0; i < pN_CH; i++) sat_cnt[i] <= '0;
      end else if (adv && win_vld && sat_clip(q_win) && (sat_cnt[win_idx] != 16'hFFFF)) begin
        sat_cnt[win_idx] <= sat_cnt[win_idx] + 16'd1;
      end
    end
  end

  always_comb begin
    osat_cnt = '0;
    for (int i = 0; i < pN_CH; i++) osat_cnt[i*16 +: 16] = sat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_rounding_sched.sv
// Scoreboard bench for rounding_sched: accepted samples push modelled results,
// delivered outputs are matched per channel; scenario tasks check ordering and timing.
module tb_rounding_sched;
  localparam int N  = 4;
  localparam int IW = 24;
  localparam int OW = 8;
  localparam int D  = 16;

  logic iclk = 1'b0;
  logic ireset;
  logic iclkena;

  rounding_sched_if #(.pN_CH(N), .pIDAT_W(IW), .pODAT_W(OW)) bus ();
  rounding_sched_if #(.pN_CH(N), .pIDAT_W(IW), .pODAT_W(OW)) bus_fs ();

  assign bus_fs.ival  = bus.ival;
  assign bus_fs.idat  = bus.idat;
  assign bus_fs.iordy = bus.iordy;

`ifdef ROUNDING_SCHED_STAT_EN
  logic           iclr_stat;
  logic [N*16-1:0] osat_cnt;
  logic [N*16-1:0] osat_cnt_fs;
`endif

  rounding_sched #(.pN_CH(N), .pIDAT_W(IW), .pODAT_W(OW), .pDIV(D), .pFULL_SCALE(0)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .bus(bus)
`ifdef ROUNDING_SCHED_STAT_EN
    , .iclr_stat(iclr_stat), .osat_cnt(osat_cnt)
`endif
  );

  rounding_sched #(.pN_CH(N), .pIDAT_W(IW), .pODAT_W(OW), .pDIV(D), .pFULL_SCALE(1)) dut_fs (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .bus(bus_fs)
`ifdef ROUNDING_SCHED_STAT_EN
    , .iclr_stat(iclr_stat), .osat_cnt(osat_cnt_fs)
`endif
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  typedef struct { int chan; int dat; } item_t;
  item_t exp_q[$];
  item_t obs_q[$];

  function automatic int model(input logic signed [IW-1:0] x, input bit fs);
    real r;
    int  q;
    int  lo;
    r  = $floor(real'(x) / (2.0 ** D) + 0.5);
    q  = $rtoi(r);
    lo = fs ? -(1 << (OW - 1)) : -((1 << (OW - 1)) - 1);
    if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic bit pop_exp(input int c, output int d);
    d = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].chan == c) begin
        d = exp_q[k].dat;
        exp_q.delete(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Values seen at the falling edge are the ones the next rising edge acts on.
  always @(negedge iclk) begin
    if (ireset === 1'b1 && iclkena === 1'b1) begin
      for (int i = 0; i < N; i++)
        if (bus.ival[i] && bus.ordy[i])
          exp_q.push_back('{i, model(bus.idat[i*IW +: IW], 1'b0)});
      if (bus.oval && bus.iordy)
        obs_q.push_back('{int'(bus.ochan), int'(bus.odat)});
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic apply_reset();
    ireset   = 1'b0;
    bus.ival = '0;
    bus.idat = '0;
    bus.iordy = 1'b1;
    iclkena  = 1'b1;
`ifdef ROUNDING_SCHED_STAT_EN
    iclr_stat = 1'b0;
`endif
    repeat (2) tick();
    exp_q.delete();
    obs_q.delete();
    ireset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ireset    = 1'b0;
    bus.ival  = '0;
    bus.idat  = '0;
    bus.iordy = 1'b1;
    iclkena   = 1'b1;
`ifdef ROUNDING_SCHED_STAT_EN
    iclr_stat = 1'b0;
`endif
    #1;
    checks++; if (bus.oval !== 1'b0) begin errors++; $display("FAIL reset_oval got %b need 0", bus.oval); end
    checks++; if (bus.ordy !== {N{1'b1}}) begin errors++; $display("FAIL reset_ordy got %b need 1111", bus.ordy); end
    checks++; if (bus.ochan !== '0) begin errors++; $display("FAIL reset_ochan got %0d need 0", bus.ochan); end
    checks++; if (bus.odat !== '0) begin errors++; $display("FAIL reset_odat got %0d need 0", bus.odat); end
    repeat (2) tick();
    exp_q.delete();
    obs_q.delete();
    ireset = 1'b1;
    tick();
  endtask

  task automatic test_rounding();
    logic [IW-1:0] vals [5];
    int req [5];
    int req_fs [5];
    item_t o;
    int d;
    vals   = '{24'h018000, 24'h017FFF, 24'hFE8000, 24'h7FFFFF, 24'h800000};
    req    = '{2, 1, -1, 127, -127};
    req_fs = '{2, 1, -1, 127, -128};
    bus.iordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.idat = '0;
      bus.idat[0 +: IW] = vals[k];
      bus.ival = 4'b0001;
      tick();
      bus.ival = '0;
      checks++; if (bus.oval !== 1'b0) begin errors++; $display("FAIL rnd_early_oval[%0d] got %b need 0", k, bus.oval); end
      tick();
      checks++; if (bus.oval !== 1'b1) begin errors++; $display("FAIL rnd_lat_oval[%0d] got %b need 1", k, bus.oval); end
      checks++; if (bus.ochan !== '0) begin errors++; $display("FAIL rnd_ochan[%0d] got %0d need 0", k, bus.ochan); end
      checks++; if (int'(bus.odat) !== req[k]) begin errors++; $display("FAIL rnd_odat[%0d] got %0d need %0d", k, bus.odat, req[k]); end
      checks++; if (int'(bus_fs.odat) !== req_fs[k]) begin errors++; $display("FAIL rnd_fs_odat[%0d] got %0d need %0d", k, bus_fs.odat, req_fs[k]); end
      @(negedge iclk); #1;
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL rnd_sb unexpected chan %0d dat %0d", o.chan, o.dat); end
        else if (o.dat !== d) begin errors++; $display("FAIL rnd_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    item_t o;
    int d;
    int n;
    apply_reset();
    for (int i = 0; i < N; i++) bus.idat[i*IW +: IW] = IW'(i * 32'h10000);
    bus.ival = '1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c >= 1) begin
        checks++; if (bus.oval !== 1'b1) begin errors++; $display("FAIL rr_oval cycle %0d got %b need 1", c, bus.oval); end
      end
    end
    bus.ival = '0;
    repeat (8) tick();
    n = obs_q.size();
    checks++; if (n < 19) begin errors++; $display("FAIL rr_count got %0d need >=19", n); end
    for (int k = 0; k < n; k++) begin
      o = obs_q.pop_front();
      checks++; if (o.chan !== k % N) begin errors++; $display("FAIL rr_order[%0d] got %0d need %0d", k, o.chan, k % N); end
      checks++;
      if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL rr_sb unexpected chan %0d", o.chan); end
      else if (o.dat !== d || o.dat !== o.chan) begin errors++; $display("FAIL rr_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_lost got %0d pending need 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int seq [5];
    item_t o;
    int d;
    seq = '{0, 1, 2, 3, 0};
    apply_reset();
    bus.iordy = 1'b0;
    for (int i = 0; i < N; i++) bus.idat[i*IW +: IW] = IW'((i + 1) * 32'h10000);
    bus.ival = '1;
    repeat (3) tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.oval !== 1'b1) begin errors++; $display("FAIL bp_oval[%0d] got %b need 1", c, bus.oval); end
      checks++; if (bus.ochan !== '0) begin errors++; $display("FAIL bp_ochan[%0d] got %0d need 0", c, bus.ochan); end
      checks++; if (int'(bus.odat) !== 1) begin errors++; $display("FAIL bp_odat[%0d] got %0d need 1", c, bus.odat); end
      checks++; if (bus.ordy !== '0) begin errors++; $display("FAIL bp_ordy[%0d] got %b need 0000", c, bus.ordy); end
      tick();
    end
    bus.iordy = 1'b1;
    bus.ival  = '0;
    repeat (8) tick();
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d need 5", obs_q.size()); end
    for (int k = 0; k < 5 && obs_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      checks++; if (o.chan !== seq[k]) begin errors++; $display("FAIL bp_order[%0d] got %0d need %0d", k, o.chan, seq[k]); end
      checks++;
      if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL bp_sb unexpected chan %0d", o.chan); end
      else if (o.dat !== d) begin errors++; $display("FAIL bp_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost got %0d pending need 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int seq [3];
    item_t o;
    int d;
    seq = '{1, 3, 1};
    apply_reset();
    bus.idat[1*IW +: IW] = 24'h050000;
    bus.ival = 4'b0010;
    tick();
    bus.ival = '0;
    tick();
    bus.iordy = 1'b0;
    bus.idat[1*IW +: IW] = 24'h010000;
    bus.idat[3*IW +: IW] = 24'h030000;
    bus.ival = 4'b1010;
    tick();
    bus.ival = '0;
    tick();
    bus.iordy = 1'b1;
    repeat (6) tick();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL wrap_count got %0d need 3", obs_q.size()); end
    for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      checks++; if (o.chan !== seq[k]) begin errors++; $display("FAIL wrap_order[%0d] got %0d need %0d", k, o.chan, seq[k]); end
      checks++;
      if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL wrap_sb unexpected chan %0d", o.chan); end
      else if (o.dat !== d) begin errors++; $display("FAIL wrap_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
    end
  endtask

  task automatic test_reset_mid();
    item_t o;
    int d;
    apply_reset();
    bus.iordy = 1'b0;
    for (int i = 0; i < 3; i++) bus.idat[i*IW +: IW] = IW'((i + 1) * 32'h20000);
    bus.ival = 4'b0111;
    repeat (3) tick();
    checks++; if (bus.oval !== 1'b1) begin errors++; $display("FAIL mid_pre_oval got %b need 1", bus.oval); end
    checks++; if (bus.ordy !== 4'b1000) begin errors++; $display("FAIL mid_pre_ordy got %b need 1000", bus.ordy); end
    bus.ival = '0;
    ireset = 1'b0;
    #1;
    checks++; if (bus.oval !== 1'b0) begin errors++; $display("FAIL mid_oval got %b need 0", bus.oval); end
    checks++; if (bus.ordy !== {N{1'b1}}) begin errors++; $display("FAIL mid_ordy got %b need 1111", bus.ordy); end
    checks++; if (bus.odat !== '0) begin errors++; $display("FAIL mid_odat got %0d need 0", bus.odat); end
    exp_q.delete();
    obs_q.delete();
    @(negedge iclk); #1;
    ireset = 1'b1;
    bus.iordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.oval !== 1'b0) begin errors++; $display("FAIL mid_idle_oval[%0d] got %b need 0", c, bus.oval); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_ghost got %0d outputs need 0", obs_q.size()); end
    bus.idat[2*IW +: IW] = 24'h040000;
    bus.ival = 4'b0100;
    tick();
    bus.ival = '0;
    tick();
    checks++; if (bus.oval !== 1'b1 || bus.ochan !== 2'd2 || int'(bus.odat) !== 4) begin
      errors++; $display("FAIL mid_new got oval %b chan %0d dat %0d need 1 2 4", bus.oval, bus.ochan, bus.odat);
    end
    repeat (2) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL mid_sb unexpected chan %0d", o.chan); end
      else if (o.dat !== d) begin errors++; $display("FAIL mid_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
    end
  endtask

  task automatic test_clkena();
    item_t o;
    int d;
    apply_reset();
    iclkena = 1'b0;
    bus.idat[0 +: IW] = 24'h030000;
    bus.ival = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.ordy !== {N{1'b1}} || bus.oval !== 1'b0) begin
        errors++; $display("FAIL ena_noload[%0d] got ordy %b oval %b need 1111 0", c, bus.ordy, bus.oval);
      end
    end
    iclkena = 1'b1;
    tick();
    iclkena = 1'b0;
    bus.ival = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.ordy !== 4'b1110 || bus.oval !== 1'b0) begin
        errors++; $display("FAIL ena_nogrant[%0d] got ordy %b oval %b need 1110 0", c, bus.ordy, bus.oval);
      end
    end
    iclkena = 1'b1;
    tick();
    iclkena = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.oval !== 1'b1 || int'(bus.odat) !== 3) begin
        errors++; $display("FAIL ena_frozen[%0d] got oval %b dat %0d need 1 3", c, bus.oval, bus.odat);
      end
    end
    iclkena = 1'b1;
    repeat (3) tick();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL ena_count got %0d need 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (!pop_exp(o.chan, d)) begin errors++; $display("FAIL ena_sb unexpected chan %0d", o.chan); end
      else if (o.dat !== d) begin errors++; $display("FAIL ena_sb chan %0d got %0d need %0d", o.chan, o.dat, d); end
    end
  endtask

`ifdef ROUNDING_SCHED_STAT_EN
  task automatic test_stat();
    int want;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      bus.idat[2*IW +: IW] = 24'h7FFFFF;
      bus.ival = 4'b0100;
      tick();
      bus.ival = '0;
      tick();
    end
    repeat (4) tick();
    for (int i = 0; i < N; i++) begin
      want = (i == 2) ? 3 : 0;
      checks++; if (int'(osat_cnt[i*16 +: 16]) !== want) begin
        errors++; $display("FAIL stat_cnt[%0d] got %0d need %0d", i, osat_cnt[i*16 +: 16], want);
      end
    end
    iclr_stat = 1'b1;
    tick();
    iclr_stat = 1'b0;
    checks++; if (osat_cnt !== '0) begin errors++; $display("FAIL stat_clr got %h need 0", osat_cnt); end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rounding();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_clkena();
`ifdef ROUNDING_SCHED_STAT_EN
    test_stat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
